// File: rtl/simd_decoder_pipe.sv
// simd_decoder_pipe: decodes custom SIMD instructions into a registered
// operand/op bundle, with a per-register pending scoreboard for RAW/WAW
// hazards and a saturating count of illegal instructions.
// Optional feature: define SIMD_DEC_SHIFT_EN to decode sra (op 4) and
// srl (op 5); without it those encodings are treated as illegal.
module simd_decoder_pipe #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        op,
  output logic [1:0]        esize,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  output logic [ADDR_W-1:0] rd,
  output logic              rs1_rd_en,
  output logic              rs2_rd_en,
  output logic              rd_wr_en,
  output logic              illegal,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int         NREG   = 1 << ADDR_W;
  localparam logic [6:0] OPCODE = 7'b1110111;

  logic [6:0]        opcode_f;
  logic [2:0]        func3_f;
  logic [6:0]        func7_f;
  logic [4:0]        rd_raw;
  logic [4:0]        rs1_raw;
  logic [4:0]        rs2_raw;
  logic [ADDR_W-1:0] rd_f;
  logic [ADDR_W-1:0] rs1_f;
  logic [ADDR_W-1:0] rs2_f;

  logic [2:0]        dec_op;
  logic              op_ok;
  logic [1:0]        dec_esize;
  logic              size_ok;
  logic              fields_ok;
  logic              legal;

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pend_seen;
  logic [NREG-1:0]   pending_next;
  logic              hazard;
  logic              accept;

  assign opcode_f = instruction[6:0];
  assign rd_raw   = instruction[11:7];
  assign func3_f  = instruction[14:12];
  assign rs1_raw  = instruction[19:15];
  assign rs2_raw  = instruction[24:20];
  assign func7_f  = instruction[31:25];

  assign rd_f  = rd_raw[ADDR_W-1:0];
  assign rs1_f = rs1_raw[ADDR_W-1:0];
  assign rs2_f = rs2_raw[ADDR_W-1:0];

  // Register fields wider than the register file make the instruction illegal
  assign fields_ok = ((rd_raw  >> ADDR_W) == 5'd0) &&
                     ((rs1_raw >> ADDR_W) == 5'd0) &&
                     ((rs2_raw >> ADDR_W) == 5'd0);

  // Map func7 to an operation and func3 to an element size
  always_comb begin
    dec_op    = 3'd0;
    op_ok     = 1'b0;
    dec_esize = 2'd0;
    size_ok   = 1'b0;
    case (func7_f)
      7'b0100000: begin dec_op = 3'd0; op_ok = 1'b1; end
      7'b0100001: begin dec_op = 3'd1; op_ok = 1'b1; end
      7'b1010000: begin dec_op = 3'd2; op_ok = 1'b1; end
      7'b1110011: begin dec_op = 3'd3; op_ok = 1'b1; end
`ifdef SIMD_DEC_SHIFT_EN
      7'b0100010: begin dec_op = 3'd4; op_ok = 1'b1; end
      7'b0100011: begin dec_op = 3'd5; op_ok = 1'b1; end
`endif
      default:    begin dec_op = 3'd0; op_ok = 1'b0; end
    endcase
    case (func3_f)
      3'b000:  begin dec_esize = 2'd0; size_ok = 1'b1; end
      3'b001:  begin dec_esize = 2'd1; size_ok = 1'b1; end
      3'b010:  begin dec_esize = 2'd2; size_ok = 1'b1; end
      default: begin dec_esize = 2'd0; size_ok = 1'b0; end
    endcase
  end

  assign legal = (opcode_f == OPCODE) && op_ok && size_ok && fields_ok;

  // Pending bits as seen this cycle: a same-cycle writeback already frees its register
  always_comb begin
    pend_seen = pending;
    if (wb_valid) begin
      pend_seen[wb_rd] = 1'b0;
    end
  end

  assign hazard   = legal && (pend_seen[rs1_f] || pend_seen[rs2_f] || pend_seen[rd_f]);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Next scoreboard: writeback clears first, then a legal acceptance marks rd (set wins)
  always_comb begin
    pending_next = pend_seen;
    if (accept && legal) begin
      pending_next[rd_f] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Output bundle register: load on acceptance, drop valid once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      op        <= 3'd0;
      esize     <= 2'd0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      rs1_rd_en <= 1'b0;
      rs2_rd_en <= 1'b0;
      rd_wr_en  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      illegal   <= !legal;
      op        <= legal ? dec_op    : 3'd0;
      esize     <= legal ? dec_esize : 2'd0;
      rs1       <= legal ? rs1_f     : '0;
      rs2       <= legal ? rs2_f     : '0;
      rd        <= legal ? rd_f      : '0;
      rs1_rd_en <= legal;
      rs2_rd_en <= legal;
      rd_wr_en  <= legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && !legal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_decoder_pipe.sv
// tb_simd_decoder_pipe: directed and randomized checks of simd_decoder_pipe
// against a cycle-level reference model of the decode rules, scoreboard,
// output handshake and illegal counter. Honours SIMD_DEC_SHIFT_EN.
module tb_simd_decoder_pipe;

  typedef struct packed {
    logic       illegal;
    logic [2:0] op;
    logic [1:0] esize;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] en;
  } bundle_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [1:0]  esize;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        rs1_rd_en;
  logic        rs2_rd_en;
  logic        rd_wr_en;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [7:0]  illegal_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit      m_valid;
  bundle_t m_b;
  bit      m_pend [32];
  int      m_cnt;
  logic    last_ready;

  simd_decoder_pipe #(.ADDR_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .esize(esize), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en), .rd_wr_en(rd_wr_en),
    .illegal(illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] s2, input logic [4:0] s1,
                                     input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b1110111};
  endfunction

  // Decode by table lookup: index of the matching func7 is the op number
  function automatic bundle_t refDecode(input logic [31:0] ins);
    bundle_t    b;
    logic [6:0] codes [6];
    int         n;
    codes = '{7'b0100000, 7'b0100001, 7'b1010000, 7'b1110011, 7'b0100010, 7'b0100011};
`ifdef SIMD_DEC_SHIFT_EN
    n = 6;
`else
    n = 4;
`endif
    b = '0;
    b.illegal = 1'b1;
    if (ins[6:0] == 7'h77 && ins[14:12] <= 3'd2) begin
      for (int k = 0; k < n; k++) begin
        if (ins[31:25] == codes[k]) begin
          b.illegal = 1'b0;
          b.op      = 3'(k);
          b.esize   = 2'(ins[14:12]);
          b.rs1     = ins[19:15];
          b.rs2     = ins[24:20];
          b.rd      = ins[11:7];
          b.en      = 3'b111;
        end
      end
    end
    return b;
  endfunction

  function automatic bundle_t obsBundle();
    return {illegal, op, esize, rs1, rs2, rd, rs1_rd_en, rs2_rd_en, rd_wr_en};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // One cycle: drive at the falling edge, check in_ready, advance model, check registered outputs
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic ordy,
                               input logic wbv, input logic [4:0] wbr);
    bundle_t d;
    logic    hz, rdy, acc;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    wb_valid    = wbv;
    wb_rd       = wbr;
    #1;
    d  = refDecode(ins);
    hz = 1'b0;
    if (!d.illegal) begin
      hz = (m_pend[d.rs1] && !(wbv && wbr == d.rs1)) ||
           (m_pend[d.rs2] && !(wbv && wbr == d.rs2)) ||
           (m_pend[d.rd]  && !(wbv && wbr == d.rd));
    end
    rdy = (!m_valid || ordy) && !hz;
    last_ready = in_ready;
    checkOutput("in_ready", in_ready, rdy);
    acc = v && rdy;
    if (wbv) m_pend[wbr] = 1'b0;
    if (acc && !d.illegal) m_pend[d.rd] = 1'b1;
    if (acc) begin
      m_valid = 1'b1;
      m_b     = d;
      if (d.illegal && m_cnt < 255) m_cnt++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", out_valid, m_valid);
    if (m_valid) checkOutput("bundle", obsBundle(), m_b);
    checkOutput("illegal_cnt", illegal_cnt, m_cnt);
    @(negedge clk);
  endtask

  task automatic modelReset();
    m_valid = 1'b0;
    m_b     = '0;
    m_cnt   = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  initial begin
    logic [6:0]  f7tab [6];
    logic [31:0] ins;
    f7tab = '{7'b0100000, 7'b0100001, 7'b1010000, 7'b1110011, 7'b0100010, 7'b0100011};
    modelReset();
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0;

    #3;
    checkOutput("reset_state", {out_valid, obsBundle(), illegal_cnt}, '0);

    // Release reset at a falling edge; the very next rising edge accepts
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h4000_8177, 1'b1, 1'b0, 5'd0);
    checkOutput("first_add", {out_valid, obsBundle()}, {1'b1, 1'b0, 3'd0, 2'd0, 5'd1, 5'd0, 5'd2, 3'b111});

    // rs1/rs2 = r2 is pending: stall until writeback of r2, which bypasses
    applyStimulus(1'b1, 32'h4021_0277, 1'b1, 1'b0, 5'd0);
    checkOutput("raw_stall", last_ready, 1'b0);
    applyStimulus(1'b1, 32'h4021_0277, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 32'h4021_0277, 1'b1, 1'b1, 5'd2);
    checkOutput("bypass_accept", last_ready, 1'b1);
    checkOutput("bypass_rd", rd, 5'd4);

    applyStimulus(1'b1, 32'hE600_1077, 1'b1, 1'b0, 5'd0);
    checkOutput("bitrev_op_esize", {op, esize}, {3'd3, 2'd1});

    // sra depends on r0 (pending from bitrev); free it in the same cycle
    applyStimulus(1'b1, 32'h4400_0077, 1'b1, 1'b1, 5'd0);
`ifdef SIMD_DEC_SHIFT_EN
    checkOutput("sra_decode", {illegal, op, illegal_cnt}, {1'b0, 3'd4, 8'd0});
`else
    checkOutput("sra_illegal", {illegal, op, illegal_cnt}, {1'b1, 3'd0, 8'd1});
`endif

    // Hold a bundle for three stalled cycles, then complete both handshakes at once
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd4);
    applyStimulus(1'b1, mk(7'b0100000, 3'd0, 5'd7, 5'd6, 5'd5), 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mk(7'b0100001, 3'd2, 5'd3, 5'd3, 5'd3), 1'b0, 1'b0, 5'd0);
      checkOutput("hold_ready", last_ready, 1'b0);
      checkOutput("hold_bundle", {op, rd, rs1, rs2}, {3'd0, 5'd5, 5'd6, 5'd7});
    end
    applyStimulus(1'b1, mk(7'b0100001, 3'd2, 5'd3, 5'd3, 5'd3), 1'b1, 1'b0, 5'd0);
    checkOutput("b2b_accept", {last_ready, out_valid, op, esize, rd}, {1'b1, 1'b1, 3'd1, 2'd2, 5'd3});

    // Writeback of a clear register is harmless; same-cycle set and clear keeps the set
    applyStimulus(1'b1, mk(7'b1010000, 3'd0, 5'd9, 5'd9, 5'd9), 1'b1, 1'b1, 5'd9);
    applyStimulus(1'b1, mk(7'b0100000, 3'd0, 5'd9, 5'd10, 5'd11), 1'b1, 1'b0, 5'd0);
    checkOutput("set_wins", last_ready, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd9);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        ins = mk(f7tab[$urandom_range(0, 5)], 3'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end else begin
        ins = $urandom;
      end
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
    end

    // Flood of illegal instructions saturates the counter
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      ins[6:0] = 7'h33;
      applyStimulus(1'b1, ins, 1'b1, 1'b0, 5'd0);
    end
    checkOutput("cnt_saturated", illegal_cnt, 8'd255);

    // Asynchronous reset in the middle of the stream, away from any rising edge
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {out_valid, obsBundle(), illegal_cnt}, '0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, mk(7'b0100000, 3'd1, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 5'd0);
    checkOutput("post_reset_accept", {last_ready, out_valid, rd}, {1'b1, 1'b1, 5'd3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
